// File: rtl/port_tx_arbiter_if.sv
// Shared port transmit bus between the requesters and the packet arbiter.
// The arbiter sits on the slave modport; the requester side drives master.
interface port_tx_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]     iv_req;
  logic [NUM_REQ-1:0]     ov_ack;
  logic [NUM_REQ*134-1:0] iv_data;
  logic [NUM_REQ-1:0]     iv_data_wr;
  logic [6:0]             iv_fifo_usedw;
  logic [133:0]           ov_data;
  logic                   o_data_wr;
  logic                   o_busy;
  logic [15:0]            ov_timeout_cnt;

  modport master (
    output iv_req,
    output iv_data,
    output iv_data_wr,
    output iv_fifo_usedw,
    input  ov_ack,
    input  ov_data,
    input  o_data_wr,
    input  o_busy,
    input  ov_timeout_cnt
  );

  modport slave (
    input  iv_req,
    input  iv_data,
    input  iv_data_wr,
    input  iv_fifo_usedw,
    output ov_ack,
    output ov_data,
    output o_data_wr,
    output o_busy,
    output ov_timeout_cnt
  );
endinterface

// File: rtl/port_tx_arbiter.sv
// Packet-granular round-robin arbiter onto one 134-bit port transmit bus,
// gated by downstream FIFO headroom, with a stalled-requester watchdog.
module port_tx_arbiter #(
  parameter int         NUM_REQ   = 3,
  parameter logic [6:0] USEDW_MAX = 7'd30,
  parameter logic [7:0] TIMEOUT   = 8'd255
) (
  input  logic           i_clk,
  input  logic           i_rst,
  port_tx_arbiter_if.slave bus
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [IW-1:0]      gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [133:0]       data_q, data_d;
  logic               wr_q, wr_d;
  logic [7:0]         wdog_q, wdog_d;
  logic [15:0]        cnt_q, cnt_d;

  logic               found;
  logic [IW-1:0]      winner;
  logic               grant_ok;
  logic [133:0]       beat;
  logic               beat_wr;
  logic               beat_tail;
  logic               wdog_hit;

  // Round-robin: scan above the last winner first, then wrap.
  always_comb begin
    found  = 1'b0;
    winner = rr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && k > int'(rr_q) && bus.iv_req[k]) begin
        found  = 1'b1;
        winner = IW'(k);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && k <= int'(rr_q) && bus.iv_req[k]) begin
        found  = 1'b1;
        winner = IW'(k);
      end
    end
  end

  assign grant_ok = found && (bus.iv_fifo_usedw <= USEDW_MAX);

  always_comb begin
    beat    = '0;
    beat_wr = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (int'(gnt_q) == k) begin
        beat    = bus.iv_data[k*134 +: 134];
        beat_wr = bus.iv_data_wr[k];
      end
    end
  end

  assign beat_tail = (beat[133:132] == 2'b10);
  assign wdog_hit  = ((wdog_q + 8'd1) == TIMEOUT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      rr_q    <= IW'(NUM_REQ - 1);
      gnt_q   <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      wdog_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      wdog_q  <= wdog_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_ok) state_d = GRANT;
      end
      GRANT: begin
        state_d = XFER;
      end
      XFER: begin
        if (beat_wr) begin
          if (beat_tail) state_d = IDLE;
        end else if (wdog_hit) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ack_d  = '0;
    wr_d   = 1'b0;
    data_d = data_q;
    rr_d   = rr_q;
    gnt_d  = gnt_q;
    wdog_d = wdog_q;
    cnt_d  = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant_ok) begin
          ack_d = NUM_REQ'(1) << winner;
          gnt_d = winner;
          rr_d  = winner;
        end
      end
      GRANT: begin
        wdog_d = '0;
      end
      XFER: begin
        if (beat_wr) begin
          data_d = beat;
          wr_d   = 1'b1;
          wdog_d = '0;
        end else begin
          wdog_d = wdog_q + 8'd1;
          // Abandon silently; no synthetic tail is emitted.
          if (wdog_hit && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        wdog_d = '0;
      end
    endcase
  end

  assign bus.ov_ack         = ack_q;
  assign bus.ov_data        = data_q;
  assign bus.o_data_wr      = wr_q;
  assign bus.o_busy         = (state_q != IDLE);
  assign bus.ov_timeout_cnt = cnt_q;

endmodule

// File: tb/tb_port_tx_arbiter.sv
// Directed and randomized bench for port_tx_arbiter against a
// packet-level reference model of the grant order and forwarded beats.
module tb_port_tx_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  port_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  port_tx_arbiter #(
    .NUM_REQ  (N),
    .USEDW_MAX(7'd30),
    .TIMEOUT  (8'd255)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_rr  = N - 1;
  int m_cnt = 0;

  task automatic chk(input string tag, input logic [133:0] obs,
                     input logic [133:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [133:0] rnd_beat(input logic [1:0] flag);
    logic [133:0] v;
    v[31:0]    = $urandom;
    v[63:32]   = $urandom;
    v[95:64]   = $urandom;
    v[127:96]  = $urandom;
    v[133:128] = 6'($urandom);
    v[133:132] = flag;
    return v;
  endfunction

  task automatic set_data(input int k, input logic [133:0] v);
    bus.iv_data[k*134 +: 134] = v;
  endtask

  // Winner = first requester strictly after the last winner, with wrap.
  function automatic int exp_winner(input logic [N-1:0] req);
    int c;
    for (int i = 1; i <= N; i++) begin
      c = (m_rr + i) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic grant(input logic [N-1:0] req, input logic [6:0] usedw,
                       output int w);
    logic [N-1:0] e;
    bus.iv_req        = req;
    bus.iv_fifo_usedw = usedw;
    w = exp_winner(req);
    e = N'(1) << w;
    tick();
    chk("ack_pulse", 134'(bus.ov_ack), 134'(e));
    chk("busy_grant", 134'(bus.o_busy), 134'(1));
    chk("wr_grant", 134'(bus.o_data_wr), 134'(0));
    m_rr = w;
    bus.iv_req = bus.iv_req & ~e;
    tick();
    chk("ack_drop", 134'(bus.ov_ack), 134'(0));
    chk("busy_xfer", 134'(bus.o_busy), 134'(1));
  endtask

  task automatic xfer(input int w, input int nbeats, input int maxgap);
    int g;
    logic [1:0] flag;
    logic [133:0] v;
    for (int b = 0; b < nbeats; b++) begin
      g = $urandom_range(0, maxgap);
      repeat (g) begin
        bus.iv_data_wr = '0;
        set_data(w, rnd_beat(2'b10));
        for (int k = 0; k < N; k++) begin
          if (k != w && $urandom_range(0, 1) == 1) begin
            set_data(k, 134'h3_DEAD);
            bus.iv_data_wr = bus.iv_data_wr | (N'(1) << k);
          end
        end
        tick();
        chk("wr_gap", 134'(bus.o_data_wr), 134'(0));
        chk("busy_gap", 134'(bus.o_busy), 134'(1));
      end
      flag = (b == nbeats - 1) ? 2'b10 : (b == 0) ? 2'b01 : 2'b11;
      v = rnd_beat(flag);
      bus.iv_data_wr = N'(1) << w;
      set_data(w, v);
      for (int k = 0; k < N; k++) begin
        if (k != w && $urandom_range(0, 1) == 1) begin
          set_data(k, rnd_beat(2'($urandom)));
          bus.iv_data_wr = bus.iv_data_wr | (N'(1) << k);
        end
      end
      tick();
      chk("wr_beat", 134'(bus.o_data_wr), 134'(1));
      chk("data_beat", bus.ov_data, v);
      chk("busy_beat", 134'(bus.o_busy), 134'(b != nbeats - 1));
    end
    bus.iv_data_wr = '0;
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    bus.iv_req        = '0;
    bus.iv_data_wr    = '0;
    bus.iv_data       = '0;
    bus.iv_fifo_usedw = '0;
    tick();
    tick();
    rst   = 1'b0;
    m_rr  = N - 1;
    m_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    int order [6];
    logic [N-1:0] req;
    logic [6:0] u;
    logic [133:0] v;

    order = '{0, 1, 2, 0, 1, 2};

    do_reset();
    chk("rst_ack", 134'(bus.ov_ack), 134'(0));
    chk("rst_data", bus.ov_data, 134'(0));
    chk("rst_wr", 134'(bus.o_data_wr), 134'(0));
    chk("rst_busy", 134'(bus.o_busy), 134'(0));
    chk("rst_tocnt", 134'(bus.ov_timeout_cnt), 134'(0));

    grant(3'b001, 7'd0, w);
    chk("single_who", 134'(w), 134'(0));
    xfer(w, 4, 0);
    tick();
    chk("single_idle", 134'(bus.o_busy), 134'(0));

    do_reset();
    for (int p = 0; p < 6; p++) begin
      grant(3'b111, 7'd0, w);
      chk("fair_order", 134'(w), 134'(order[p]));
      xfer(w, 2, 1);
    end
    bus.iv_req = '0;

    bus.iv_req        = 3'b010;
    bus.iv_fifo_usedw = 7'd31;
    repeat (50) begin
      tick();
      chk("bp_noack", 134'(bus.ov_ack), 134'(0));
      chk("bp_idle", 134'(bus.o_busy), 134'(0));
    end
    grant(3'b010, 7'd30, w);
    chk("bp_who", 134'(w), 134'(1));
    bus.iv_fifo_usedw = 7'd127;
    xfer(w, 4, 2);
    bus.iv_fifo_usedw = 7'd0;

    bus.iv_req        = 3'b001;
    bus.iv_fifo_usedw = 7'd31;
    tick();
    chk("drop_noack0", 134'(bus.ov_ack), 134'(0));
    bus.iv_req        = '0;
    bus.iv_fifo_usedw = 7'd0;
    tick();
    chk("drop_noack1", 134'(bus.ov_ack), 134'(0));
    chk("drop_idle", 134'(bus.o_busy), 134'(0));

    grant(3'b100, 7'd0, w);
    chk("wd_who", 134'(w), 134'(2));
    v = rnd_beat(2'b01);
    set_data(2, v);
    bus.iv_data_wr = 3'b100;
    tick();
    chk("wd_head", bus.ov_data, v);
    bus.iv_data_wr = '0;
    repeat (254) tick();
    chk("wd_still_busy", 134'(bus.o_busy), 134'(1));
    chk("wd_cnt_before", 134'(bus.ov_timeout_cnt), 134'(m_cnt));
    tick();
    m_cnt++;
    chk("wd_abandon", 134'(bus.o_busy), 134'(0));
    chk("wd_cnt", 134'(bus.ov_timeout_cnt), 134'(m_cnt));
    chk("wd_no_tail", 134'(bus.o_data_wr), 134'(0));
    repeat (9) tick();
    set_data(2, rnd_beat(2'b10));
    bus.iv_data_wr = 3'b100;
    tick();
    bus.iv_data_wr = '0;
    chk("wd_late", 134'(bus.o_data_wr), 134'(0));
    chk("wd_late_idle", 134'(bus.o_busy), 134'(0));

    grant(3'b001, 7'd0, w);
    v = rnd_beat(2'b01);
    set_data(0, v);
    bus.iv_data_wr = 3'b001;
    tick();
    chk("mr_beat1", bus.ov_data, v);
    set_data(0, rnd_beat(2'b11));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.iv_data_wr = '0;
    m_rr  = N - 1;
    m_cnt = 0;
    chk("mr_wr", 134'(bus.o_data_wr), 134'(0));
    chk("mr_busy", 134'(bus.o_busy), 134'(0));
    chk("mr_ack", 134'(bus.ov_ack), 134'(0));
    chk("mr_tocnt", 134'(bus.ov_timeout_cnt), 134'(0));
    grant(3'b010, 7'd5, w);
    chk("mr_regrant", 134'(w), 134'(1));
    xfer(w, 3, 2);

    repeat (20) begin
      req = N'($urandom_range(1, (1 << N) - 1));
      u   = 7'($urandom_range(0, 60));
      if (u > 7'd30) begin
        bus.iv_req        = req;
        bus.iv_fifo_usedw = u;
        tick();
        chk("rnd_full_noack", 134'(bus.ov_ack), 134'(0));
        chk("rnd_full_idle", 134'(bus.o_busy), 134'(0));
        u = 7'($urandom_range(0, 30));
      end
      grant(req, u, w);
      xfer(w, $urandom_range(2, 6), 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
